// File: rtl/jt12_modbuf_if.sv
// jt12_modbuf_if: slot-side bus between the modulation-routing decoder, the
// operator write-back path and the modulation buffer.
//   rd_ch, s*_enters       channel and one-hot operator entering this slot
//   xuse_*, yuse_*         x/y source selects from the routing decoder
//   fb_I                   S1 self-feedback level for rd_ch (0 = off)
//   op_we/op_ch/op_sel     write strobe, channel and operator of a result
//   op_result              signed 14-bit finished operator output
//   mod_out, mod_valid     signed 10-bit phase modulation and its valid flag
// master drives the slot and write signals; slave is the buffer itself.
interface jt12_modbuf_if;
  logic [2:0]  rd_ch;
  logic        s1_enters;
  logic        s2_enters;
  logic        s3_enters;
  logic        s4_enters;
  logic        xuse_prevprev1;
  logic        xuse_prev2;
  logic        xuse_internal;
  logic        yuse_prev1;
  logic        yuse_prev2;
  logic        yuse_internal;
  logic [2:0]  fb_I;
  logic        op_we;
  logic [2:0]  op_ch;
  logic [1:0]  op_sel;
  logic [13:0] op_result;
  logic [9:0]  mod_out;
  logic        mod_valid;

  modport master (
    output rd_ch, s1_enters, s2_enters, s3_enters, s4_enters,
           xuse_prevprev1, xuse_prev2, xuse_internal,
           yuse_prev1, yuse_prev2, yuse_internal, fb_I,
           op_we, op_ch, op_sel, op_result,
    input  mod_out, mod_valid
  );

  modport slave (
    input  rd_ch, s1_enters, s2_enters, s3_enters, s4_enters,
           xuse_prevprev1, xuse_prev2, xuse_internal,
           yuse_prev1, yuse_prev2, yuse_internal, fb_I,
           op_we, op_ch, op_sel, op_result,
    output mod_out, mod_valid
  );
endinterface

// File: rtl/jt12_modbuf.sv
// jt12_modbuf: per-channel operator-output history and modulation summer.
// Keeps, per channel, the last two S1 outputs plus the latest S2 and S3
// outputs, picks the x/y modulation sources named by the routing decoder
// for the operator entering this slot, sums them and scales the result
// into a 10-bit phase-modulation word. Two-stage pipeline on clk_en.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset (clears history and pipeline)
//   clk_en  slot advance; nothing changes while low
//   bus     slave side of jt12_modbuf_if (slot, write and result signals)
// Parameter:
//   num_ch  number of channels held in history (6 or 3)
module jt12_modbuf #(
  parameter int num_ch = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  jt12_modbuf_if.slave   bus
);

  typedef struct packed {
    logic [13:0] tap_pp1;
    logic [13:0] tap_p1;
    logic [13:0] tap_p2;
    logic [13:0] tap_int;
    logic        x_pp1;
    logic        x_p2;
    logic        x_int;
    logic        y_p1;
    logic        y_int;
    logic [2:0]  fb;
    logic        is_s1;
    logic        legal;
  } stage1_t;

  logic [13:0] s1a [num_ch];
  logic [13:0] s1b [num_ch];
  logic [13:0] s2  [num_ch];
  logic [13:0] s3  [num_ch];

  stage1_t     st1;
  stage1_t     st1_next;

  logic [13:0] h_s1a, h_s1b, h_s2, h_s3;
  logic [3:0]  enters;
  logic        legal;

  // yuse_prev2 has no tap behind it in this pipeline; it is deliberately ignored.
  logic unused_sel;
  assign unused_sel = bus.yuse_prev2;

  assign enters = {bus.s4_enters, bus.s3_enters, bus.s2_enters, bus.s1_enters};
  assign legal  = $onehot(enters) && (bus.rd_ch < 3'(num_ch));

  // History read for rd_ch; an out-of-range channel reads zeros.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    h_s1a = '0;
    h_s1b = '0;
    h_s2  = '0;
    h_s3  = '0;
    for (int c = 0; c < num_ch; c++) begin
      if (bus.rd_ch == 3'(c)) begin
        h_s1a = s1a[c];
        h_s1b = s1b[c];
        h_s2  = s2[c];
        h_s3  = s3[c];
      end
    end
  end

  // Tap mapping for the entering operator; unlisted taps read zero.
  always_comb begin
    st1_next       = '0;
    st1_next.x_pp1 = bus.xuse_prevprev1;
    st1_next.x_p2  = bus.xuse_prev2;
    st1_next.x_int = bus.xuse_internal;
    st1_next.y_p1  = bus.yuse_prev1;
    st1_next.y_int = bus.yuse_internal;
    st1_next.fb    = bus.fb_I;
    st1_next.is_s1 = bus.s1_enters;
    st1_next.legal = legal;
    if (bus.s1_enters) begin
      st1_next.tap_pp1 = h_s1b;
      st1_next.tap_p1  = h_s1a;
    end else if (bus.s2_enters) begin
      st1_next.tap_p1  = h_s1a;
    end else if (bus.s3_enters) begin
      st1_next.tap_pp1 = h_s1a;
      st1_next.tap_p1  = h_s1a;
      st1_next.tap_p2  = h_s2;
    end else if (bus.s4_enters) begin
      st1_next.tap_pp1 = h_s3;
      st1_next.tap_p2  = h_s2;
      st1_next.tap_p1  = h_s1a;
      st1_next.tap_int = h_s3;
    end
  end

  // Stage 2: source priority, sum and scaling.
  logic [13:0]        x_val, y_val;
  logic signed [14:0] sum;
  logic signed [14:0] fb_shifted;
  logic [3:0]         fb_shamt;
  logic [9:0]         mod_next;

  always_comb begin
    x_val = '0;
    if      (st1.x_pp1) x_val = st1.tap_pp1;
    else if (st1.x_p2)  x_val = st1.tap_p2;
    else if (st1.x_int) x_val = st1.tap_int;

    y_val = '0;
    if      (st1.y_p1)  y_val = st1.tap_p1;
    else if (st1.y_int) y_val = st1.tap_int;
  end

  assign sum        = {x_val[13], x_val} + {y_val[13], y_val};
  assign fb_shamt   = 4'd9 - {1'b0, st1.fb};
  assign fb_shifted = sum >>> fb_shamt;

  always_comb begin
    mod_next = '0;
    if (st1.legal) begin
      if (st1.is_s1) mod_next = (st1.fb == 3'd0) ? 10'd0 : fb_shifted[9:0];
      else           mod_next = sum[10:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the history is a handful of registers, not a RAM macro, so it
      // is cleared on reset along with the pipeline.
      for (int c = 0; c < num_ch; c++) begin
        s1a[c] <= '0;
        s1b[c] <= '0;
        s2[c]  <= '0;
        s3[c]  <= '0;
      end
      st1           <= '0;
      bus.mod_out   <= '0;
      bus.mod_valid <= 1'b0;
    end else if (clk_en) begin
      // NOTE: non-blocking assignments make the stage-1 read below see the
      // history as it stood before this edge's write (read-before-write).
      if (bus.op_we) begin
        for (int c = 0; c < num_ch; c++) begin
          if (bus.op_ch == 3'(c)) begin
            case (bus.op_sel)
              2'd0: begin
                s1b[c] <= s1a[c];
                s1a[c] <= bus.op_result;
              end
              2'd1:    s2[c] <= bus.op_result;
              2'd2:    s3[c] <= bus.op_result;
              default: ;  // S4 output is not kept
            endcase
          end
        end
      end
      st1           <= st1_next;
      bus.mod_out   <= mod_next;
      bus.mod_valid <= st1.legal;
    end
  end

endmodule

// File: tb/tb_jt12_modbuf.sv
// tb_jt12_modbuf: directed test of jt12_modbuf. A six-channel and a
// three-channel instance see the same stimulus; the three-channel outputs
// are checked where channel count matters.
module tb_jt12_modbuf;

  logic clk;
  logic rst;
  logic clk_en;
  int   checks = 0;
  int   errors = 0;

  jt12_modbuf_if bus ();
  jt12_modbuf_if bus3 ();

  assign bus3.rd_ch          = bus.rd_ch;
  assign bus3.s1_enters      = bus.s1_enters;
  assign bus3.s2_enters      = bus.s2_enters;
  assign bus3.s3_enters      = bus.s3_enters;
  assign bus3.s4_enters      = bus.s4_enters;
  assign bus3.xuse_prevprev1 = bus.xuse_prevprev1;
  assign bus3.xuse_prev2     = bus.xuse_prev2;
  assign bus3.xuse_internal  = bus.xuse_internal;
  assign bus3.yuse_prev1     = bus.yuse_prev1;
  assign bus3.yuse_prev2     = bus.yuse_prev2;
  assign bus3.yuse_internal  = bus.yuse_internal;
  assign bus3.fb_I           = bus.fb_I;
  assign bus3.op_we          = bus.op_we;
  assign bus3.op_ch          = bus.op_ch;
  assign bus3.op_sel         = bus.op_sel;
  assign bus3.op_result      = bus.op_result;

  jt12_modbuf #(.num_ch(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  jt12_modbuf #(.num_ch(3)) dut3 (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] S1 = 4'b0001, S2 = 4'b0010, S3 = 4'b0100, S4 = 4'b1000;
  // select vector order: {xuse_prevprev1, xuse_prev2, xuse_internal, yuse_prev1, yuse_internal}
  localparam logic [4:0] SEL_Y_P1   = 5'b00010;
  localparam logic [4:0] SEL_PP1_P1 = 5'b10010;
  localparam logic [4:0] SEL_X_P2   = 5'b01000;
  localparam logic [4:0] SEL_P2_INT = 5'b01001;
  localparam logic [4:0] SEL_PP1_P2 = 5'b11000;

  task automatic idle();
    {bus.s4_enters, bus.s3_enters, bus.s2_enters, bus.s1_enters} = 4'b0000;
    {bus.xuse_prevprev1, bus.xuse_prev2, bus.xuse_internal} = 3'b000;
    {bus.yuse_prev1, bus.yuse_prev2, bus.yuse_internal} = 3'b000;
    bus.rd_ch     = 3'd0;
    bus.fb_I      = 3'd0;
    bus.op_we     = 1'b0;
    bus.op_ch     = 3'd0;
    bus.op_sel    = 2'd0;
    bus.op_result = 14'd0;
  endtask

  task automatic drive_slot(input logic [3:0] ent, input logic [2:0] ch,
                            input logic [4:0] sel, input logic [2:0] fb);
    {bus.s4_enters, bus.s3_enters, bus.s2_enters, bus.s1_enters} = ent;
    {bus.xuse_prevprev1, bus.xuse_prev2, bus.xuse_internal,
     bus.yuse_prev1, bus.yuse_internal} = sel;
    bus.yuse_prev2 = 1'b0;
    bus.rd_ch = ch;
    bus.fb_I  = fb;
  endtask

  task automatic write_op(input logic [2:0] ch, input logic [1:0] sel, input logic [13:0] val);
    @(negedge clk);
    bus.op_we     = 1'b1;
    bus.op_ch     = ch;
    bus.op_sel    = sel;
    bus.op_result = val;
    @(negedge clk);
    bus.op_we = 1'b0;
  endtask

  // Drives one slot, then returns at the negedge after its result lands.
  task automatic read_slot(input logic [3:0] ent, input logic [2:0] ch,
                           input logic [4:0] sel, input logic [2:0] fb);
    @(negedge clk);
    drive_slot(ent, ch, sel, fb);
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_en = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: mod_out=%h valid=%b, want 000/0", bus.mod_out, bus.mod_valid);
    end
    rst = 1'b0;
    write_op(3'd0, 2'd0, 14'h0100);
    read_slot(S2, 3'd0, SEL_Y_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h080 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: mod_out=%h valid=%b, want 080/1", bus.mod_out, bus.mod_valid);
    end
    clk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b0 ||
        bus3.mod_out !== 10'h000 || bus3.mod_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midstream: mod_out=%h valid=%b mod3=%h valid3=%b, want 000/0",
               bus.mod_out, bus.mod_valid, bus3.mod_out, bus3.mod_valid);
    end
    rst = 1'b0;
    clk_en = 1'b1;
    read_slot(S2, 3'd0, SEL_Y_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_history: mod_out=%h valid=%b, want 000/1", bus.mod_out, bus.mod_valid);
    end
  endtask

  task automatic test_s2_path();
    write_op(3'd2, 2'd0, 14'h0400);
    read_slot(S2, 3'd2, SEL_Y_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h200 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL s2_path: mod_out=%h valid=%b, want 200/1", bus.mod_out, bus.mod_valid);
    end
  endtask

  task automatic test_feedback();
    write_op(3'd0, 2'd0, 14'h0200);
    write_op(3'd0, 2'd0, 14'h0600);
    read_slot(S1, 3'd0, SEL_PP1_P1, 3'd7);
    checks++;
    if (bus.mod_out !== 10'h200 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL fb7: mod_out=%h valid=%b, want 200/1", bus.mod_out, bus.mod_valid);
    end
    read_slot(S1, 3'd0, SEL_PP1_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL fb0: mod_out=%h valid=%b, want 000/1", bus.mod_out, bus.mod_valid);
    end
    read_slot(S1, 3'd0, SEL_PP1_P1, 3'd1);
    checks++;
    if (bus.mod_out !== 10'h008 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL fb1: mod_out=%h valid=%b, want 008/1", bus.mod_out, bus.mod_valid);
    end
  endtask

  task automatic test_s4();
    write_op(3'd3, 2'd2, 14'h1FFF);
    write_op(3'd3, 2'd0, 14'h2000);
    write_op(3'd3, 2'd1, 14'h0010);
    read_slot(S4, 3'd3, SEL_PP1_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h3FF || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL s4_dual: mod_out=%h valid=%b, want 3FF/1", bus.mod_out, bus.mod_valid);
    end
    read_slot(S4, 3'd3, SEL_P2_INT, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h007 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL s4_prev2_internal: mod_out=%h valid=%b, want 007/1", bus.mod_out, bus.mod_valid);
    end
    read_slot(S4, 3'd3, SEL_PP1_P2, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h3FF || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL x_priority: mod_out=%h valid=%b, want 3FF/1", bus.mod_out, bus.mod_valid);
    end
  endtask

  task automatic test_read_before_write();
    @(negedge clk);
    bus.op_we     = 1'b1;
    bus.op_ch     = 3'd1;
    bus.op_sel    = 2'd1;
    bus.op_result = 14'h0100;
    drive_slot(S3, 3'd1, SEL_X_P2, 3'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL rbw_old: mod_out=%h valid=%b, want 000/1", bus.mod_out, bus.mod_valid);
    end
    read_slot(S3, 3'd1, SEL_X_P2, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h080 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL rbw_new: mod_out=%h valid=%b, want 080/1", bus.mod_out, bus.mod_valid);
    end
  endtask

  task automatic test_illegal();
    read_slot(S2, 3'd6, SEL_Y_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_ch6: mod_out=%h valid=%b, want 000/0", bus.mod_out, bus.mod_valid);
    end
    read_slot(S1 | S2, 3'd2, SEL_Y_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b0) begin
      errors++;
      $display("FAIL not_onehot: mod_out=%h valid=%b, want 000/0", bus.mod_out, bus.mod_valid);
    end
    write_op(3'd4, 2'd0, 14'h0300);
    read_slot(S2, 3'd0, SEL_Y_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h300 || bus3.mod_out !== 10'h300 || bus3.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL ch3_op_ch4_nowrite: mod_out=%h mod3=%h valid3=%b, want 300/300/1",
               bus.mod_out, bus3.mod_out, bus3.mod_valid);
    end
    read_slot(S2, 3'd4, SEL_Y_P1, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h180 || bus.mod_valid !== 1'b1 ||
        bus3.mod_out !== 10'h000 || bus3.mod_valid !== 1'b0) begin
      errors++;
      $display("FAIL ch3_rd_ch4: mod_out=%h valid=%b mod3=%h valid3=%b, want 180/1 000/0",
               bus.mod_out, bus.mod_valid, bus3.mod_out, bus3.mod_valid);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    drive_slot(S2, 3'd2, SEL_Y_P1, 3'd0);
    @(negedge clk);
    drive_slot(S3, 3'd1, SEL_X_P2, 3'd0);
    @(negedge clk);
    clk_en = 1'b0;
    idle();
    bus.op_we     = 1'b1;
    bus.op_ch     = 3'd4;
    bus.op_sel    = 2'd1;
    bus.op_result = 14'h07FF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.mod_out !== 10'h200 || bus.mod_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: mod_out=%h valid=%b, want 200/1", i, bus.mod_out, bus.mod_valid);
      end
      @(negedge clk);
    end
    clk_en = 1'b1;
    bus.op_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mod_out !== 10'h080 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: mod_out=%h valid=%b, want 080/1", bus.mod_out, bus.mod_valid);
    end
    read_slot(S3, 3'd4, SEL_X_P2, 3'd0);
    checks++;
    if (bus.mod_out !== 10'h000 || bus.mod_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_write_ignored: mod_out=%h valid=%b, want 000/1", bus.mod_out, bus.mod_valid);
    end
  endtask

  initial begin
    test_reset();
    test_s2_path();
    test_feedback();
    test_s4();
    test_read_before_write();
    test_illegal();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
